// File: rtl/bb_seq_engine.sv
// Op-ring sequencer with per-channel request queues and round-robin grant arbitration.
// Optional sticky overflow flag ERR is built only when BB_ERR_EN is defined.
module bb_seq_engine #(
  parameter int NCH    = 2,
  parameter int NOPS   = 4,
  parameter int CNT_W  = 4,
  parameter int MAXQ   = 7,
  parameter int DATA_W = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    STALL,
  input  logic                    OPCH,
  input  logic [NCH-1:0]          REQ,
  output logic [NCH-1:0]          ACK,
  output logic [NCH-1:0]          DONE,
  output logic [NCH*DATA_W-1:0]   DATA,
  output logic [NOPS-1:0]         OPS,
  output logic                    TEST,
  output logic                    WRAP,
  output logic                    BUSY,
  output logic                    ERR
);

  localparam int QW = $clog2(MAXQ + 1);
  localparam int OW = $clog2(NOPS);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t              state;
  logic [OW-1:0]       op;
  logic [OW-1:0]       nxt_op;
  logic [NOPS-1:0]     ops_q;
  logic [CNT_W-1:0]    cnt;
  logic [QW-1:0]       q [NCH];
  logic [PW-1:0]       ptr;
  logic [NCH-1:0]      grant;
  logic [NCH-1:0]      ack_q;
  logic [NCH-1:0]      done_q;
  logic [NCH*DATA_W-1:0] data_q;
  logic                err_q;
  logic                busy;
  logic                found;
  int                  gidx;
  int                  idx;

  always_comb begin
    nxt_op = op;
    if (OPCH) nxt_op = (op == OW'(NOPS - 1)) ? '0 : op + OW'(1);
    else      nxt_op = (op == '0) ? OW'(NOPS - 1) : op - OW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      op    <= '0;
      ops_q <= '0;
    end else if (!STALL) begin
      case (state)
        IDLE: begin
          state <= RUN;
          op    <= '0;
          ops_q <= NOPS'(1);
        end
        RUN: begin
          op    <= nxt_op;
          ops_q <= NOPS'(1) << nxt_op;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt <= '0;
    else     cnt <= cnt + CNT_W'(1);
  end

  // Round-robin search starts one past the last granted channel.
  always_comb begin
    grant = '0;
    found = 1'b0;
    gidx  = 0;
    idx   = 0;
    if (!STALL) begin
      for (int k = 1; k <= NCH; k++) begin
        idx = (int'(ptr) + k) % NCH;
        if (!found && q[idx] != '0) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
          gidx       = idx;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) q[i] <= '0;
      ptr    <= PW'(NCH - 1);
      ack_q  <= '0;
      done_q <= '0;
      data_q <= '0;
    end else begin
      ack_q <= grant;
      if (found) ptr <= PW'(gidx);
      for (int i = 0; i < NCH; i++) begin
        // A request arriving at a full queue is dropped unless the same edge grants.
        if (REQ[i] && !grant[i]) begin
          if (q[i] != QW'(MAXQ)) q[i] <= q[i] + QW'(1);
        end else if (!REQ[i] && grant[i]) begin
          q[i] <= q[i] - QW'(1);
        end
        done_q[i] <= grant[i] && !REQ[i] && (q[i] == QW'(1));
        if (grant[i])
          data_q[i*DATA_W +: DATA_W] <= data_q[i*DATA_W +: DATA_W] + DATA_W'(1);
      end
    end
  end

`ifdef BB_ERR_EN
  logic ovf;

  always_comb begin
    ovf = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (REQ[i] && !grant[i] && q[i] == QW'(MAXQ)) ovf = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      err_q <= 1'b0;
    else if (ovf) err_q <= 1'b1;
  end
`else
  assign err_q = 1'b0;
`endif

  always_comb begin
    busy = |ack_q;
    for (int i = 0; i < NCH; i++)
      if (q[i] != '0) busy = 1'b1;
  end

  assign ACK  = ack_q;
  assign DONE = done_q;
  assign DATA = data_q;
  assign OPS  = ops_q;
  assign TEST = (cnt == '0);
  assign WRAP = &cnt;
  assign BUSY = busy;
  assign ERR  = err_q;

endmodule
